dlf_k_filter: RTL and testbench

Parametrised K-counter digital loop filter for the DPLL, the next generation of the team's fixed-modulus loop filter. It sits between the phase detector and the increment/decrement (digitally controlled oscillator) stage. It integrates the phase-error sign over a runtime-programmable modulus and emits single-cycle `add`/`sub` correction pulses. It offers a shared-counter mode and a dual up/down-counter mode, and adds a lock detector with hysteresis.

---
 rtl/dlf_pkg.sv | 11 +
 rtl/dlf_lock_det.sv | 53 +++++
 rtl/dlf_k_filter.sv | 118 +++++++++++
 tb/tb_dlf_k_filter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dlf_pkg.sv
// Shared constants for the K-counter DPLL loop filter: mode select and
// correction direction encodings.
package dlf_pkg;

  localparam logic MODE_SHARED = 1'b0;
  localparam logic MODE_DUAL   = 1'b1;

  localparam logic DIR_ADD = 1'b0;
  localparam logic DIR_SUB = 1'b1;

endpackage

// File: rtl/dlf_lock_det.sv
// Lock detector with hysteresis: lock is declared after LOCK_N correction-free
// cycles and dropped only on two consecutive same-direction corrections.
module dlf_lock_det
  import dlf_pkg::*;
#(
  parameter int LOCK_W = 8,
  parameter int LOCK_N = 200
) (
  input  logic clk_2,
  input  logic rst_n,
  input  logic add,
  input  logic sub,
  output logic locked
);

  localparam logic [LOCK_W-1:0] GAP_MAX = LOCK_W'(LOCK_N);
  localparam logic [LOCK_W-1:0] GAP_PRE = LOCK_W'(LOCK_N - 1);

  logic [LOCK_W-1:0] gap;
  logic              last_dir;
  logic              last_vld;
  logic              pulse;
  logic              dir;

  assign pulse = add | sub;
  assign dir   = sub ? DIR_SUB : DIR_ADD;

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      gap      <= '0;
      last_dir <= DIR_ADD;
      last_vld <= 1'b0;
      locked   <= 1'b0;
    end else if (pulse) begin
      gap      <= '0;
      last_dir <= dir;
      last_vld <= 1'b1;
      // Alternating corrections are normal dithering around lock; a repeat
      // in the same direction means the loop is really drifting.
      if (last_vld && (dir == last_dir)) begin
        locked <= 1'b0;
      end
    end else begin
      if (gap != GAP_MAX) begin
        gap <= gap + 1'b1;
      end
      if (gap == GAP_PRE) begin
        locked <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dlf_k_filter.sv
// K-counter digital loop filter: integrates the phase-error sign over a
// programmable modulus and emits single-cycle add/sub correction pulses.
module dlf_k_filter
  import dlf_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int LOCK_W = 8,
  parameter int LOCK_N = 200
) (
  input  logic             clk_2,
  input  logic             rst_n,
  input  logic             se,
  input  logic             err_vld,
  input  logic [CNT_W-1:0] k_lim,
  input  logic             mode,
  output logic             add,
  output logic             sub,
  output logic             locked
);

  logic             se_q;
  logic [CNT_W-1:0] k_q;
  logic             mode_q;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] up_cnt, up_nxt;
  logic [CNT_W-1:0] dn_cnt, dn_nxt;
  logic [CNT_W-1:0] k_m1;
  logic             cfg_chg;
  logic             carry_add;
  logic             carry_sub;

  // k_eff - 1, with k_lim = 0 treated as a modulus of 1.
  assign k_m1    = (k_q == '0) ? '0 : k_q - 1'b1;
  assign cfg_chg = (k_lim != k_q) || (mode != mode_q);

  always_comb begin
    cnt_nxt   = cnt;
    up_nxt    = up_cnt;
    dn_nxt    = dn_cnt;
    carry_add = 1'b0;
    carry_sub = 1'b0;
    if (cfg_chg) begin
      cnt_nxt = '0;
      up_nxt  = '0;
      dn_nxt  = '0;
    end else if (err_vld) begin
      if (mode_q == MODE_SHARED) begin
        // A sign flip restarts the run with this cycle as its first count.
        if (se != se_q) begin
          if (k_m1 == '0) begin
            cnt_nxt = '0;
            if (se == DIR_SUB) carry_sub = 1'b1;
            else               carry_add = 1'b1;
          end else begin
            cnt_nxt = CNT_W'(1);
          end
        end else if (cnt == k_m1) begin
          cnt_nxt = '0;
          if (se == DIR_SUB) carry_sub = 1'b1;
          else               carry_add = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else begin
        if (se == DIR_ADD) begin
          if (up_cnt == k_m1) begin
            up_nxt    = '0;
            carry_add = 1'b1;
          end else begin
            up_nxt = up_cnt + 1'b1;
          end
        end else begin
          if (dn_cnt == k_m1) begin
            dn_nxt    = '0;
            carry_sub = 1'b1;
          end else begin
            dn_nxt = dn_cnt + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      se_q   <= 1'b0;
      k_q    <= '0;
      mode_q <= MODE_SHARED;
      cnt    <= '0;
      up_cnt <= '0;
      dn_cnt <= '0;
      add    <= 1'b0;
      sub    <= 1'b0;
    end else begin
      se_q   <= se;
      k_q    <= k_lim;
      mode_q <= mode;
      cnt    <= cnt_nxt;
      up_cnt <= up_nxt;
      dn_cnt <= dn_nxt;
      add    <= carry_add;
      sub    <= carry_sub;
    end
  end

  dlf_lock_det #(
    .LOCK_W (LOCK_W),
    .LOCK_N (LOCK_N)
  ) u_lock_det (
    .clk_2  (clk_2),
    .rst_n  (rst_n),
    .add    (add),
    .sub    (sub),
    .locked (locked)
  );

endmodule

// File: tb/tb_dlf_k_filter.sv
// Directed bench for dlf_k_filter: shared/dual counting, k_lim edge values,
// config-change clearing, async reset and lock hysteresis.
module tb_dlf_k_filter;

  localparam int CNT_W  = 4;
  localparam int LOCK_W = 8;
  localparam int LOCK_N = 10;

  logic             clk_2 = 1'b0;
  logic             rst_n;
  logic             se;
  logic             err_vld;
  logic [CNT_W-1:0] k_lim;
  logic             mode;
  logic             add;
  logic             sub;
  logic             locked;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  exp_q[$];
  logic [1:0]  exp_v;

  always #5 clk_2 = ~clk_2;

  dlf_k_filter #(
    .CNT_W  (CNT_W),
    .LOCK_W (LOCK_W),
    .LOCK_N (LOCK_N)
  ) dut (
    .clk_2   (clk_2),
    .rst_n   (rst_n),
    .se      (se),
    .err_vld (err_vld),
    .k_lim   (k_lim),
    .mode    (mode),
    .add     (add),
    .sub     (sub),
    .locked  (locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    checks++;
    if (obs !== exp_val) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp_val, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic cyc(input string tag, input logic e_add, input logic e_sub);
    step();
    chk({tag, "_add"}, {31'd0, add}, {31'd0, e_add});
    chk({tag, "_sub"}, {31'd0, sub}, {31'd0, e_sub});
  endtask

  initial begin
    rst_n   = 1'b0;
    se      = 1'b0;
    err_vld = 1'b0;
    k_lim   = '0;
    mode    = 1'b0;
    repeat (3) step();
    chk("rst_add", {31'd0, add}, 32'd0);
    chk("rst_sub", {31'd0, sub}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    rst_n = 1'b1;

    // lock set after LOCK_N quiet cycles
    k_lim = 4'd15;
    repeat (LOCK_N - 1) step();
    chk("lock_pre", {31'd0, locked}, 32'd0);
    step();
    chk("lock_set", {31'd0, locked}, 32'd1);
    repeat (2) step();
    chk("lock_hold", {31'd0, locked}, 32'd1);

    // add then sub keeps lock; a second sub drops it
    k_lim = 4'd1;
    cyc("lk_cfg", 1'b0, 1'b0);
    err_vld = 1'b1;
    se      = 1'b0;
    cyc("lk_add", 1'b1, 1'b0);
    chk("lock_first", {31'd0, locked}, 32'd1);
    se = 1'b1;
    cyc("lk_sub1", 1'b0, 1'b1);
    chk("lock_after_add", {31'd0, locked}, 32'd1);
    err_vld = 1'b0;
    cyc("lk_gap", 1'b0, 1'b0);
    chk("lock_alt", {31'd0, locked}, 32'd1);
    err_vld = 1'b1;
    cyc("lk_sub2", 1'b0, 1'b1);
    chk("lock_pre_clr", {31'd0, locked}, 32'd1);
    err_vld = 1'b0;
    cyc("lk_end", 1'b0, 1'b0);
    chk("lock_clr", {31'd0, locked}, 32'd0);

    // k_lim = 0 behaves as modulus 1: sub every qualified cycle
    k_lim   = 4'd0;
    err_vld = 1'b1;
    se      = 1'b1;
    cyc("k0_cfg", 1'b0, 1'b0);
    repeat (5) cyc("k0_run", 1'b0, 1'b1);
    err_vld = 1'b0;
    repeat (3) cyc("k0_hold", 1'b0, 1'b0);
    err_vld = 1'b1;
    cyc("k0_resume", 1'b0, 1'b1);

    // shared mode, K=15, steady lag: add after 15th and 30th qualified cycle
    err_vld = 1'b0;
    se      = 1'b0;
    k_lim   = 4'd15;
    mode    = 1'b0;
    repeat (2) step();
    for (int i = 1; i <= 40; i++) begin
      exp_q.push_back((i == 15 || i == 30) ? 2'b10 : 2'b00);
    end
    err_vld = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      exp_v = exp_q.pop_front();
      chk("k15", {30'd0, add, sub}, {30'd0, exp_v});
    end

    // shared mode, K=4: partial lead run is discarded on sign flip
    err_vld = 1'b0;
    se      = 1'b1;
    k_lim   = 4'd4;
    repeat (2) step();
    err_vld = 1'b1;
    repeat (3) cyc("k4_lead", 1'b0, 1'b0);
    se = 1'b0;
    repeat (3) cyc("k4_lag", 1'b0, 1'b0);
    cyc("k4_add", 1'b1, 1'b0);

    // dual mode, K=4, alternating sign: add/sub every 8 cycles, interleaved
    err_vld = 1'b0;
    mode    = 1'b1;
    k_lim   = 4'd4;
    se      = 1'b0;
    repeat (2) step();
    for (int i = 1; i <= 16; i++) begin
      if (i == 7 || i == 15)      exp_q.push_back(2'b10);
      else if (i == 8 || i == 16) exp_q.push_back(2'b01);
      else                        exp_q.push_back(2'b00);
    end
    err_vld = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      se = ((i % 2) == 0);
      step();
      exp_v = exp_q.pop_front();
      chk("dual", {30'd0, add, sub}, {30'd0, exp_v});
    end

    // k_lim 8 -> 5 mid-count clears without a pulse
    err_vld = 1'b0;
    mode    = 1'b0;
    se      = 1'b0;
    k_lim   = 4'd8;
    repeat (2) step();
    err_vld = 1'b1;
    repeat (5) cyc("k8_run", 1'b0, 1'b0);
    k_lim = 4'd5;
    cyc("k_chg", 1'b0, 1'b0);
    repeat (4) cyc("k5_run", 1'b0, 1'b0);
    cyc("k5_add", 1'b1, 1'b0);

    // async reset while add is high
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_add", {31'd0, add}, 32'd0);
    chk("rst_async_locked", {31'd0, locked}, 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    chk("rel_add", {31'd0, add}, 32'd0);
    chk("rel_sub", {31'd0, sub}, 32'd0);
    chk("rel_locked", {31'd0, locked}, 32'd0);
    cyc("rel_cfg", 1'b0, 1'b0);
    repeat (4) cyc("rel_run", 1'b0, 1'b0);
    cyc("rel_add1", 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
